dual_sram_responder: RTL and testbench
======================================

Name: dual_sram_responder

Overview:
- Memory-side responder for the 5-stage CPU's two SRAM buses.
- Instruction bank: CPU drives addr_0 and receives inst_rdata (read-only).
- Data bank: CPU drives addr_1, data_wdata and we_n, and receives data_rdata.
- A boot-load handshake port fills the instruction bank before the CPU runs. cpu_run is the CPU's go signal.

Parameters:
- ADDR_WIDTH, 16, width of addr_0, addr_1 and load_addr.
- DATA_WIDTH, 16, word width.
- DEPTH_LOG2, 8, each bank holds 2^DEPTH_LOG2 words; address bits above this are ignored.
- RD_LAT, 1, read latency in clk cycles; legal values are 1 and 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- addr_0  in  ADDR_WIDTH  instruction read address.
- inst_rdata  out  DATA_WIDTH  instruction read data.
- addr_1  in  ADDR_WIDTH  data read/write address.
- data_wdata  in  DATA_WIDTH  data write value.
- we_n  in  1  data write enable, active-low.
- data_rdata  out  DATA_WIDTH  data read data.
- load_valid  in  1  boot word offered.
- load_ready  out  1  boot word can be accepted.
- load_addr  in  ADDR_WIDTH  boot word address.
- load_data  in  DATA_WIDTH  boot word.
- load_done  in  1  loader finished.
- cpu_run  out  1  CPU may fetch.

Behaviour:
- Reset is async on the falling edge of reset_n. While reset is asserted:
  - state = LOAD; load_ready = 1; cpu_run = 0.
  - inst_rdata = 0, data_rdata = 0, and all read pipeline registers = 0.
  - Bank contents are NOT reset and are retained across reset.
- FSM has two states, LOAD and RUN.
  - In LOAD, load_ready = 1.
  - Transfer occurs on a posedge where load_valid && load_ready: bank0[load_addr[DEPTH_LOG2-1:0]] <= load_data.
  - load_done sampled high in LOAD moves to RUN at that edge. From the next cycle cpu_run = 1 and load_ready = 0.
  - If load_valid and load_done are high on the same edge, the word is written first, then the FSM enters RUN.
  - In RUN, load_valid and load_done are ignored. Only reset returns the FSM to LOAD.
  - Reset in the middle of a load: FSM returns to LOAD, words already written are kept, and the loader restarts or resumes freely.
- Reads are active in both states.
  - Address sampled at edge k; data appears at the output after edge k+RD_LAT-1 and holds until the next update.
  - Both ports read independently every cycle.
- Data writes:
  - Only in RUN: on a posedge with we_n = 0, bank1[addr_1 idx] <= data_wdata.
  - we_n = 0 in LOAD is ignored (no write).
- Read/write collisions are write-first:
  - A read of the data bank at the same index in the same cycle as a write returns data_wdata.
  - A boot write to bank0 at the same index as the addr_0 read in the same cycle returns load_data.
- Wrap-around: indices are addr[DEPTH_LOG2-1:0]; e.g. with DEPTH_LOG2 = 8, address 16'h0105 aliases 16'h0005.
- When RD_LAT = 2, one extra register stage follows the array read. Bypassed write-first data passes through the same stage.
- RD_LAT outside {1,2} is an elaboration error.

Optional Feature:
- Macro: DUAL_SRAM_LOAD_DATA_EN.
- Defined: adds input load_sel (1 bit). With load_sel = 0 the boot write targets bank0; with load_sel = 1 it targets bank1, so data tables can be preloaded. Collision bypass applies to whichever bank is written.
- Undefined: load_sel does not exist and boot writes always target bank0.

Decomposition:
- Package dual_sram_pkg holds:
  - the state enum {LOAD, RUN};
  - constants RD_LAT_MIN = 1 and RD_LAT_MAX = 2.
- Sub-module sram_bank:
  - 2^DEPTH_LOG2 x DATA_WIDTH array;
  - one write port (we, waddr, wdata) and one read port;
  - write-first bypass and an RD_LAT-deep output pipe, with async-reset output regs;
  - instantiated twice.
- The top level holds the FSM, the handshake and the write-enable muxing.

Test Plan:
- Reset, then load 3 words (addr 0..2 = 16'h2004, 16'h1005, 16'h7800) with load_done on the last beat -> load_ready drops and cpu_run = 1 the next cycle; addr_0 = 1 gives inst_rdata = 16'h1005 after RD_LAT.
- In RUN, write addr_1 = 5, data_wdata = 16'hABCD, we_n = 0, while reading addr_1 = 5 the same cycle -> data_rdata = 16'hABCD (write-first); a later read also returns 16'hABCD.
- we_n = 0 during LOAD with addr_1 = 7, data_wdata = 16'h1111 -> bank1[7] is unchanged after entering RUN.
- Alias: write addr_1 = 16'h0105, value 16'h00FF, then read addr_1 = 16'h0005 -> 16'h00FF.
- Assert reset_n mid-load after 2 of 4 words -> outputs reset to 0 and cpu_run = 0; after completing the load, the words written earlier are still readable.
- With RD_LAT = 2, toggle addr_0 each cycle -> inst_rdata lags the address by 2 edges. With DUAL_SRAM_LOAD_DATA_EN defined, load_sel = 1 to addr 3, value 16'h0042 -> data_rdata = 16'h0042 for addr_1 = 3, and bank0[3] is unchanged.

Source files
------------

// File: rtl/dual_sram_pkg.sv
// Shared types and constants for the dual SRAM responder.
package dual_sram_pkg;

  // Boot sequencing: LOAD fills the instruction bank, RUN lets the CPU go.
  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Supported read latencies of a bank, in clk cycles.
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/sram_bank.sv
// Single-write, single-read SRAM bank with write-first bypass and an
// RD_LAT-deep registered read path. Array contents are not reset.
module sram_bank
  import dual_sram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("sram_bank: RD_LAT must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0] pipe [RD_LAT];

  // Array write port.
  // NOTE: the storage array deliberately has no reset so it maps onto real
  // SRAM and keeps its contents across reset; only the output pipe resets.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first read: a same-cycle write to the read index wins over the array.
  always_comb begin
    rd_next = mem[raddr];
    if (we && (waddr == raddr)) begin
      rd_next = wdata;
    end
  end

  // Read pipeline; stage 0 captures the array/bypass value, later stages delay it.
  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's old value and the pipe shifts by one per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= rd_next;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/dual_sram_responder.sv
// Memory-side responder for the CPU's instruction and data SRAM buses, with
// a boot-load handshake that fills memory before cpu_run is raised.
// Optional feature macro DUAL_SRAM_LOAD_DATA_EN: adds load_sel so boot
// writes can target the data bank (load_sel = 1) instead of the
// instruction bank (load_sel = 0).
module dual_sram_responder
  import dual_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] addr_0,
  output logic [DATA_WIDTH-1:0] inst_rdata,
  input  logic [ADDR_WIDTH-1:0] addr_1,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  we_n,
  output logic [DATA_WIDTH-1:0] data_rdata,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_done,
`ifdef DUAL_SRAM_LOAD_DATA_EN
  input  logic                  load_sel,
`endif
  output logic                  cpu_run
);

  state_t                state;
  logic                  boot_fire;
  logic                  cpu_we;
  logic                  bank0_we;
  logic                  bank1_we;
  logic [DEPTH_LOG2-1:0] bank1_waddr;
  logic [DATA_WIDTH-1:0] bank1_wdata;
  logic                  unused_addr_bits;

  // Address bits above the bank index alias onto the same words.
  assign unused_addr_bits = ^{addr_0, addr_1, load_addr};

  // Boot/run sequencer with registered handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= LOAD;
      load_ready <= 1'b1;
      cpu_run    <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (load_done) begin
            state      <= RUN;
            load_ready <= 1'b0;
            cpu_run    <= 1'b1;
          end
        end
        RUN: begin
          // Only reset leaves RUN.
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

  assign boot_fire = load_valid && load_ready;
  assign cpu_we    = (state == RUN) && !we_n;

`ifdef DUAL_SRAM_LOAD_DATA_EN
  // Boot words are steered by load_sel; boot writes only happen in LOAD,
  // so they never contend with CPU data writes.
  always_comb begin
    bank0_we    = boot_fire && !load_sel;
    bank1_we    = cpu_we;
    bank1_waddr = addr_1[DEPTH_LOG2-1:0];
    bank1_wdata = data_wdata;
    if (boot_fire && load_sel) begin
      bank1_we    = 1'b1;
      bank1_waddr = load_addr[DEPTH_LOG2-1:0];
      bank1_wdata = load_data;
    end
  end
`else
  // Boot words always go to the instruction bank; the data bank is CPU-only.
  always_comb begin
    bank0_we    = boot_fire;
    bank1_we    = cpu_we;
    bank1_waddr = addr_1[DEPTH_LOG2-1:0];
    bank1_wdata = data_wdata;
  end
`endif

  sram_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LAT    (RD_LAT)
  ) u_bank0 (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (bank0_we),
    .waddr  (load_addr[DEPTH_LOG2-1:0]),
    .wdata  (load_data),
    .raddr  (addr_0[DEPTH_LOG2-1:0]),
    .rdata  (inst_rdata)
  );

  sram_bank #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LAT    (RD_LAT)
  ) u_bank1 (
    .clk    (clk),
    .reset_n(reset_n),
    .we     (bank1_we),
    .waddr  (bank1_waddr),
    .wdata  (bank1_wdata),
    .raddr  (addr_1[DEPTH_LOG2-1:0]),
    .rdata  (data_rdata)
  );

endmodule

// File: tb/tb_dual_sram_responder.sv
// Self-checking bench for dual_sram_responder: directed tables, hand-written
// corner sequences and a randomized run against a word-level memory model.
module tb_dual_sram_responder;

  localparam int AW     = 16;
  localparam int DW     = 16;
  localparam int DL     = 8;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << DL;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr_0;
  logic [DW-1:0] inst_rdata;
  logic [AW-1:0] addr_1;
  logic [DW-1:0] data_wdata;
  logic          we_n;
  logic [DW-1:0] data_rdata;
  logic          load_valid;
  logic          load_ready;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          load_done;
`ifdef DUAL_SRAM_LOAD_DATA_EN
  logic          load_sel;
`endif
  logic          cpu_run;

  always #5 clk = ~clk;

  dual_sram_responder #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH_LOG2(DL),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .addr_0    (addr_0),
    .inst_rdata(inst_rdata),
    .addr_1    (addr_1),
    .data_wdata(data_wdata),
    .we_n      (we_n),
    .data_rdata(data_rdata),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_addr (load_addr),
    .load_data (load_data),
    .load_done (load_done),
`ifdef DUAL_SRAM_LOAD_DATA_EN
    .load_sel  (load_sel),
`endif
    .cpu_run   (cpu_run)
  );

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] v;
    bit            k;   // value is known (location was written)
  } rd_t;

  logic [DW-1:0] m_bank0 [DEPTH];
  logic [DW-1:0] m_bank1 [DEPTH];
  bit            k0 [DEPTH];
  bit            k1 [DEPTH];
  bit            m_run;
  rd_t           q0 [$];
  rd_t           q1 [$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx(input logic [AW-1:0] a);
    return int'(a % DEPTH);
  endfunction

  task automatic model_reset();
    rd_t z;
    z.v = '0;
    z.k = 1'b1;
    m_run = 1'b0;
    q0.delete();
    q1.delete();
    for (int i = 0; i < RD_LAT; i++) begin
      q0.push_front(z);
      q1.push_front(z);
    end
  endtask

  // One clock edge: advance the model from current inputs, then compare.
  task automatic tick();
    bit            sel;
    bit            wr0;
    bit            wr1;
    int            ra0;
    int            ra1;
    int            wa0;
    int            wa1;
    logic [DW-1:0] wd1;
    rd_t           r0;
    rd_t           r1;
    rd_t           e0;
    rd_t           e1;
    sel = 1'b0;
`ifdef DUAL_SRAM_LOAD_DATA_EN
    sel = load_sel;
`endif
    ra0 = idx(addr_0);
    ra1 = idx(addr_1);
    wa0 = idx(load_addr);
    wr0 = !m_run && load_valid && !sel;
    wr1 = 1'b0;
    wa1 = 0;
    wd1 = '0;
    if (m_run && !we_n) begin
      wr1 = 1'b1;
      wa1 = idx(addr_1);
      wd1 = data_wdata;
    end else if (!m_run && load_valid && sel) begin
      wr1 = 1'b1;
      wa1 = idx(load_addr);
      wd1 = load_data;
    end
    if (wr0 && wa0 == ra0) begin
      r0.v = load_data;
      r0.k = 1'b1;
    end else begin
      r0.v = m_bank0[ra0];
      r0.k = k0[ra0];
    end
    if (wr1 && wa1 == ra1) begin
      r1.v = wd1;
      r1.k = 1'b1;
    end else begin
      r1.v = m_bank1[ra1];
      r1.k = k1[ra1];
    end
    if (wr0) begin
      m_bank0[wa0] = load_data;
      k0[wa0]      = 1'b1;
    end
    if (wr1) begin
      m_bank1[wa1] = wd1;
      k1[wa1]      = 1'b1;
    end
    q0.push_front(r0);
    q1.push_front(r1);
    e0 = q0[RD_LAT-1];
    e1 = q1[RD_LAT-1];
    void'(q0.pop_back());
    void'(q1.pop_back());
    if (!m_run && load_done) m_run = 1'b1;
    @(posedge clk);
    #1;
    if (e0.k) check("inst_rdata", inst_rdata, e0.v);
    if (e1.k) check("data_rdata", data_rdata, e1.v);
    check("load_ready", load_ready, !m_run);
    check("cpu_run", cpu_run, m_run);
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_inst_rdata", inst_rdata, '0);
    check("rst_data_rdata", data_rdata, '0);
    check("rst_load_ready", load_ready, 1'b1);
    check("rst_cpu_run", cpu_run, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- directed tables ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            done;
    bit            exp_ready;
    bit            exp_run;
  } load_vec_t;

  typedef struct {
    logic [AW-1:0] a0;
    logic [DW-1:0] exp;
  } rd_vec_t;

  load_vec_t boot_tab [3];
  rd_vec_t   rd_tab   [4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    boot_tab[0] = '{addr: 16'h0000, data: 16'h2004, done: 1'b0, exp_ready: 1'b1, exp_run: 1'b0};
    boot_tab[1] = '{addr: 16'h0001, data: 16'h1005, done: 1'b0, exp_ready: 1'b1, exp_run: 1'b0};
    boot_tab[2] = '{addr: 16'h0002, data: 16'h7800, done: 1'b1, exp_ready: 1'b0, exp_run: 1'b1};
    rd_tab[0]   = '{a0: 16'h0001, exp: 16'h1005};
    rd_tab[1]   = '{a0: 16'h0000, exp: 16'h2004};
    rd_tab[2]   = '{a0: 16'h0002, exp: 16'h7800};
    rd_tab[3]   = '{a0: 16'h0101, exp: 16'h1005};

    reset_n    = 1'b1;
    addr_0     = '0;
    addr_1     = '0;
    data_wdata = '0;
    we_n       = 1'b1;
    load_valid = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_done  = 1'b0;
`ifdef DUAL_SRAM_LOAD_DATA_EN
    load_sel   = 1'b0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      k0[i] = 1'b0;
      k1[i] = 1'b0;
    end

    // Boot load of three words, done on the last beat.
    do_reset();
    load_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_addr = boot_tab[i].addr;
      load_data = boot_tab[i].data;
      load_done = boot_tab[i].done;
      tick();
      check("boot_ready", load_ready, boot_tab[i].exp_ready);
      check("boot_run", cpu_run, boot_tab[i].exp_run);
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_0 = rd_tab[i].a0;
      repeat (RD_LAT) tick();
      check("inst_tab", inst_rdata, rd_tab[i].exp);
    end

    // Write-first on the data bank, then a later read of the same word.
    addr_1     = 16'h0005;
    data_wdata = 16'hABCD;
    we_n       = 1'b0;
    tick();
    we_n       = 1'b1;
    data_wdata = '0;
    repeat (RD_LAT - 1) tick();
    check("wf_same_cycle", data_rdata, 16'hABCD);
    addr_1 = 16'h0000;
    repeat (RD_LAT) tick();
    addr_1 = 16'h0005;
    repeat (RD_LAT) tick();
    check("wf_later_read", data_rdata, 16'hABCD);

    // Address aliasing above the bank index.
    addr_1     = 16'h0105;
    data_wdata = 16'h00FF;
    we_n       = 1'b0;
    tick();
    we_n   = 1'b1;
    addr_1 = 16'h0005;
    repeat (RD_LAT) tick();
    check("alias_read", data_rdata, 16'h00FF);

    // Data write attempted during LOAD must be dropped.
    addr_1     = 16'h0007;
    data_wdata = 16'h5A5A;
    we_n       = 1'b0;
    tick();
    we_n = 1'b1;
    do_reset();
    data_wdata = 16'h1111;
    we_n       = 1'b0;
    tick();
    we_n      = 1'b1;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    repeat (RD_LAT) tick();
    check("load_we_ignored", data_rdata, 16'h5A5A);

    // Reset in the middle of a four-word load; loader then resumes.
    do_reset();
    load_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      load_addr = AW'(8 + i);
      load_data = DW'(16'h0A08 + i);
      tick();
    end
    load_valid = 1'b0;
    do_reset();
`ifdef DUAL_SRAM_LOAD_DATA_EN
    load_valid = 1'b1;
    load_addr  = 16'h0003;
    load_data  = 16'h3333;
    tick();
    load_sel  = 1'b1;
    load_data = 16'h0042;
    tick();
    load_sel = 1'b0;
`endif
    load_valid = 1'b1;
    for (int i = 2; i < 4; i++) begin
      load_addr = AW'(8 + i);
      load_data = DW'(16'h0A08 + i);
      load_done = (i == 3);
      tick();
    end
    load_valid = 1'b0;
    load_done  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      addr_0 = AW'(8 + i);
      repeat (RD_LAT) tick();
      check("midload_keep", inst_rdata, DW'(16'h0A08 + i));
    end
`ifdef DUAL_SRAM_LOAD_DATA_EN
    addr_0 = 16'h0003;
    addr_1 = 16'h0003;
    repeat (RD_LAT) tick();
    check("load_sel_bank1", data_rdata, 16'h0042);
    check("load_sel_bank0_kept", inst_rdata, 16'h3333);
`endif

    // Address toggling every cycle: output lags by RD_LAT edges.
    for (int i = 0; i < 8; i++) begin
      addr_0 = (i % 2 == 0) ? 16'h0000 : 16'h0001;
      tick();
    end

    // Randomized boot load followed by randomized CPU traffic.
    do_reset();
    for (int i = 0; i < 32;) begin
      load_valid = ($urandom_range(0, 3) != 0);
      load_addr  = {8'($urandom), 8'(i)};
      load_data  = DW'($urandom);
      addr_0     = {8'($urandom), 3'b000, 5'($urandom)};
      addr_1     = {8'($urandom), 4'b0000, 4'($urandom)};
      data_wdata = DW'($urandom);
      we_n       = 1'($urandom);
      tick();
      if (load_valid) i++;
    end
    load_valid = 1'b0;
    load_done  = 1'b1;
    tick();
    for (int i = 0; i < 400; i++) begin
      addr_0     = {8'($urandom), 3'b000, 5'($urandom)};
      addr_1     = {8'($urandom), 4'b0000, 4'($urandom)};
      data_wdata = DW'($urandom);
      we_n       = ($urandom_range(0, 2) != 0);
      load_valid = 1'($urandom);
      load_done  = 1'($urandom);
      load_addr  = {8'($urandom), 3'b000, 5'($urandom)};
      load_data  = DW'($urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
